// File: rtl/vram_arb_pkg.sv
// Shared definitions for the VRAM CPU-port arbiter: FSM state encoding and
// the default address/data widths.
package vram_arb_pkg;

  localparam int DEF_ADDR_W = 14;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2
  } state_t;

endpackage

// File: rtl/vram_arb_pick.sv
// Combinational winner selection between two requesters; on a tie the side
// named by pointer wins.
module vram_arb_pick (
  input  logic req0,
  input  logic req1,
  input  logic pointer,
  output logic winner
);

  assign winner = req1 & (~req0 | pointer);

endmodule

// File: rtl/vram_arbiter.sv
// Two-requester VRAM CPU-port arbiter: IDLE -> ISSUE -> CAPTURE, ack three
// cycles after the request is sampled. Define VRAM_ARB_ROUNDROBIN_EN for
// round-robin arbitration; otherwise requester 0 has fixed priority.
module vram_arbiter
  import vram_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] d0,
  input  logic [DATA_W-1:0] d1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] q,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [DATA_W-1:0] vram_d,
  output logic              vram_we,
  input  logic [DATA_W-1:0] vram_q
);

  state_t state;
  logic   grant;
  logic   winner;
  logic   pick_ptr;
  logic   any_req;

  assign any_req = req0 | req1;

  vram_arb_pick u_pick (
    .req0    (req0),
    .req1    (req1),
    .pointer (pick_ptr),
    .winner  (winner)
  );

`ifdef VRAM_ARB_ROUNDROBIN_EN
  logic pointer;

  // Pointer flips to the loser's side on every grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      pointer <= 1'b0;
    end else if (state == IDLE && any_req) begin
      pointer <= ~winner;
    end
  end

  assign pick_ptr = pointer;
`else
  assign pick_ptr = 1'b0;
`endif

  // The VRAM drive registers double as the transaction latch: they are loaded
  // when the request is accepted so the port sees them for the whole ISSUE cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      grant     <= 1'b0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      vram_we   <= 1'b0;
      vram_addr <= '0;
      vram_d    <= '0;
      q         <= '0;
    end else begin
      ack0    <= 1'b0;
      ack1    <= 1'b0;
      vram_we <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            grant     <= winner;
            vram_addr <= winner ? addr1 : addr0;
            vram_d    <= winner ? d1 : d0;
            vram_we   <= winner ? we1 : we0;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          state <= CAPTURE;
        end
        CAPTURE: begin
          q     <= vram_q;
          ack0  <= ~grant;
          ack1  <= grant;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: a cycle-scheduled transaction model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_vram_arbiter;

`ifdef VRAM_ARB_ROUNDROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  localparam int MAXC = 2048;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1, we0, we1;
  logic [13:0] addr0, addr1, vram_addr;
  logic [31:0] d0, d1, q, vram_d, vram_q;
  logic        ack0, ack1, vram_we;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  vram_arbiter #(.ADDR_W(14), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .d0(d0), .d1(d1),
    .ack0(ack0), .ack1(ack1), .q(q),
    .vram_addr(vram_addr), .vram_d(vram_d), .vram_we(vram_we),
    .vram_q(vram_q)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input int a);
    return 32'h3C00_0000 + a * 32'h0000_0101;
  endfunction

  // External VRAM device: synchronous read, one clock of latency.
  logic [31:0] vmem [0:16383];
  always @(posedge clk) begin
    vram_q <= vmem[vram_addr];
    if (vram_we) vmem[vram_addr] <= vram_d;
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Model: per-cycle expectation tables, filled when a request is accepted.
  bit [31:0] mmem [0:16383];
  bit        exp_ack0 [0:MAXC-1];
  bit        exp_ack1 [0:MAXC-1];
  bit        exp_we   [0:MAXC-1];
  bit        exp_av   [0:MAXC-1];
  bit [13:0] exp_addr [0:MAXC-1];
  bit [31:0] exp_d    [0:MAXC-1];
  bit [1:0]  exp_qev  [0:MAXC-1];
  bit [31:0] exp_qv   [0:MAXC-1];
  int        free_at = 0;
  bit        m_ptr = 1'b0;
  bit        chk_en = 1'b0;

  always @(posedge clk) begin : model
    int c;
    bit w;
    bit [13:0] a;
    c = cyc;
    if (c + 4 < MAXC) begin
      if (reset) begin
        for (int j = 1; j <= 3; j++) begin
          exp_ack0[c+j] = 0; exp_ack1[c+j] = 0; exp_we[c+j] = 0;
          exp_av[c+j] = 0; exp_qev[c+j] = 0;
        end
        exp_av[c+1] = 1; exp_addr[c+1] = '0; exp_d[c+1] = '0;
        exp_qev[c+1] = 2'd1; exp_qv[c+1] = '0;
        free_at = c + 1;
        m_ptr = 1'b0;
        chk_en = 1'b1;
      end else if (c >= free_at && (req0 || req1)) begin
        if (req0 && req1) w = RR ? m_ptr : 1'b0;
        else w = req1;
        a = w ? addr1 : addr0;
        exp_we[c+1]   = w ? we1 : we0;
        exp_av[c+1]   = 1;
        exp_addr[c+1] = a;
        exp_d[c+1]    = w ? d1 : d0;
        exp_ack0[c+3] = ~w;
        exp_ack1[c+3] = w;
        if (w ? we1 : we0) begin
          exp_qev[c+3] = 2'd2;
          mmem[a] = w ? d1 : d0;
        end else begin
          exp_qev[c+3] = 2'd1;
          exp_qv[c+3] = mmem[a];
        end
        if (RR) m_ptr = ~w;
        free_at = c + 3;
      end
    end
    cyc = c + 1;
  end

  bit        q_known = 1'b0;
  bit [31:0] q_model = '0;

  always @(negedge clk) begin : compare
    int k;
    k = cyc;
    if (chk_en && k < MAXC) begin
      if (exp_qev[k] == 2'd1) begin q_known = 1; q_model = exp_qv[k]; end
      else if (exp_qev[k] == 2'd2) q_known = 0;
      chk("m_ack0", {31'b0, ack0}, {31'b0, exp_ack0[k]});
      chk("m_ack1", {31'b0, ack1}, {31'b0, exp_ack1[k]});
      chk("m_vram_we", {31'b0, vram_we}, {31'b0, exp_we[k]});
      chk("m_ack_excl", {31'b0, ack0 & ack1}, 32'd0);
      if (exp_av[k]) begin
        chk("m_vram_addr", {18'b0, vram_addr}, {18'b0, exp_addr[k]});
        chk("m_vram_d", vram_d, exp_d[k]);
      end
      if (q_known) chk("m_q", q, q_model);
    end
  end

  task automatic do_reset();
    reset = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;
  endtask

  task automatic single(input bit side, input bit we, input logic [13:0] a,
                        input logic [31:0] d, input string nm, input bit chk_q,
                        input logic [31:0] qexp);
    if (side) begin req1 = 1; we1 = we; addr1 = a; d1 = d; end
    else begin req0 = 1; we0 = we; addr0 = a; d0 = d; end
    @(posedge clk); #1;
    req0 = 0; req1 = 0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      chk({nm, "_ack0"}, {31'b0, ack0}, {31'b0, (i == 3) && !side});
      chk({nm, "_ack1"}, {31'b0, ack1}, {31'b0, (i == 3) && side});
      chk({nm, "_we"}, {31'b0, vram_we}, {31'b0, (i == 1) && we});
      if (i == 1) begin
        chk({nm, "_addr"}, {18'b0, vram_addr}, {18'b0, a});
        if (we) chk({nm, "_d"}, vram_d, d);
      end
      if (i == 3 && chk_q) chk({nm, "_q"}, q, qexp);
    end
    @(posedge clk); #1;
  endtask

  int n, bad;
  bit order [0:3];
  int times [0:3];

  initial begin
    for (int i = 0; i < 16384; i++) begin
      vmem[i] = pat(i);
      mmem[i] = pat(i);
    end
    vmem[16'h10] = 32'hDEADBEEF;
    mmem[16'h10] = 32'hDEADBEEF;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; d0 = '0; d1 = '0;
    reset = 1;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("rst_ack0", {31'b0, ack0}, 32'd0);
    chk("rst_ack1", {31'b0, ack1}, 32'd0);
    chk("rst_we", {31'b0, vram_we}, 32'd0);
    chk("rst_addr", {18'b0, vram_addr}, 32'd0);
    chk("rst_q", q, 32'd0);
    @(posedge clk); #1;

    single(1'b0, 1'b0, 14'h010, 32'h0, "rd", 1'b1, 32'hDEADBEEF);
    single(1'b1, 1'b1, 14'h420, 32'h12345678, "wr", 1'b0, 32'h0);
    single(1'b0, 1'b0, 14'h420, 32'h0, "rdback", 1'b1, 32'h12345678);

    // Contention from a fresh pointer.
    do_reset();
    req0 = 1; we0 = 0; addr0 = 14'h010; req1 = 1; we1 = 0; addr1 = 14'h420;
    n = 0;
    for (int t = 0; t < 40 && n < 4; t++) begin
      @(negedge clk);
      if (ack0 || ack1) begin
        order[n] = ack1;
        n++;
        if (n == 4) begin req0 = 0; req1 = 0; end
      end
    end
    req0 = 0; req1 = 0;
    chk("cont_count", n, 4);
    for (int i = 0; i < 4; i++)
      chk("cont_order", {31'b0, order[i]}, {31'b0, RR ? i[0] : 1'b0});
    @(posedge clk); #1;

    // Back-to-back on requester 0.
    req0 = 1; we0 = 0; addr0 = 14'h123;
    n = 0; bad = 0;
    for (int t = 0; t < 40 && n < 4; t++) begin
      @(negedge clk);
      if (ack1) bad++;
      if (ack0) begin
        times[n] = t;
        n++;
        if (n == 4) req0 = 0;
      end
    end
    req0 = 0;
    chk("b2b_count", n, 4);
    chk("b2b_ack1", bad, 0);
    for (int i = 0; i < 3; i++) chk("b2b_spacing", times[i+1] - times[i], 3);
    @(posedge clk); #1;

    // Reset during ISSUE of a write.
    req1 = 1; we1 = 1; addr1 = 14'h055; d1 = 32'hAAAA5555;
    @(posedge clk); #1;
    req1 = 0;
    chk("mid_issue_we", {31'b0, vram_we}, 32'd1);
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    chk("mid_we", {31'b0, vram_we}, 32'd0);
    chk("mid_ack0", {31'b0, ack0}, 32'd0);
    chk("mid_ack1", {31'b0, ack1}, 32'd0);
    chk("mid_addr", {18'b0, vram_addr}, 32'd0);
    chk("mid_d", vram_d, 32'd0);
    chk("mid_q", q, 32'd0);
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (ack0 || ack1 || vram_we) bad++;
    end
    chk("mid_no_ack", bad, 0);
    @(posedge clk); #1;

    // Idle hold after a known read.
    single(1'b0, 1'b0, 14'h010, 32'h0, "rd2", 1'b1, 32'hDEADBEEF);
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (ack0 || ack1 || vram_we) bad++;
    end
    chk("idle_events", bad, 0);
    chk("idle_q", q, 32'hDEADBEEF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
